// File: rtl/test_bench.sv
// 8-bit programmable timer with an APB slave register interface.
// Registers: TDR (data), TCR (control), TSR (status flags), TCNT (read-only counter).
module test_bench #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tmr_ovf,
    output logic              tmr_udf
);

    localparam logic [ADDR_W-1:0] AddrTdr  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] AddrTcr  = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] AddrTsr  = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] AddrTcnt = ADDR_W'(8'h03);

    // Only bits 7, 5, 4, 1, 0 of TCR exist.
    localparam logic [DATA_W-1:0] TcrMask = DATA_W'(8'hB3);

    logic [DATA_W-1:0] tdr_q, tdr_d;
    logic [DATA_W-1:0] tcr_q, tcr_d;
    logic [1:0]        tsr_q, tsr_d;
    logic [DATA_W-1:0] tcnt_q, tcnt_d;
    logic [3:0]        presc_q, presc_d;

    logic       wr_en, rd_en;
    logic       load, dir, en;
    logic [1:0] cks;
    logic [3:0] tick_mask;
    logic       tick, count;
    logic       ovf_set, udf_set;

    assign wr_en = psel & penable & pwrite;
    assign rd_en = psel & penable & ~pwrite;

    assign load = tcr_q[7];
    assign dir  = tcr_q[5];
    assign en   = tcr_q[4];
    assign cks  = tcr_q[1:0];

    // CKS selects how many low prescaler bits must be all-ones: 1, 2, 3 or 4 bits.
    assign tick_mask = 4'((5'd2 << cks) - 5'd1);
    assign tick      = en & ((presc_q & tick_mask) == tick_mask);
    assign count     = tick & ~load;

    assign ovf_set = count & ~dir & (tcnt_q == {DATA_W{1'b1}});
    assign udf_set = count & dir & (tcnt_q == '0);

    assign pready  = psel & penable;
    assign pslverr = 1'b0;
    assign tmr_ovf = tsr_q[0];
    assign tmr_udf = tsr_q[1];

    // Next-state for the register file, prescaler and counter.
    always_comb begin
        tdr_d   = tdr_q;
        tcr_d   = tcr_q;
        tsr_d   = tsr_q;
        tcnt_d  = tcnt_q;
        presc_d = en ? presc_q + 4'd1 : 4'd0;

        if (wr_en) begin
            case (paddr)
                AddrTdr: tdr_d = pwdata;
                AddrTcr: tcr_d = pwdata & TcrMask;
                // Write-zero-to-clear; writing one leaves the flag alone.
                AddrTsr: tsr_d = tsr_q & pwdata[1:0];
                default: ;
            endcase
        end
        // Hardware set wins over a same-cycle software clear.
        tsr_d = tsr_d | {udf_set, ovf_set};

        if (load) begin
            tcnt_d = tdr_q;
        end else if (count) begin
            tcnt_d = dir ? tcnt_q - DATA_W'(1) : tcnt_q + DATA_W'(1);
        end
    end

    // Read mux; returns zero outside a read access phase.
    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (paddr)
                AddrTdr:  prdata = tdr_q;
                AddrTcr:  prdata = tcr_q;
                AddrTsr:  prdata = {{(DATA_W-2){1'b0}}, tsr_q};
                AddrTcnt: prdata = tcnt_q;
                default:  prdata = '0;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q   <= '0;
            tcr_q   <= '0;
            tsr_q   <= '0;
            tcnt_q  <= '0;
            presc_q <= '0;
        end else begin
            tdr_q   <= tdr_d;
            tcr_q   <= tcr_d;
            tsr_q   <= tsr_d;
            tcnt_q  <= tcnt_d;
            presc_q <= presc_d;
        end
    end

endmodule

// File: tb/tb_test_bench.sv
// Directed self-checking bench for the APB timer.
module tb_test_bench;

    logic       pclk;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf;
    logic       tmr_udf;

    int checks;
    int errors;

    test_bench #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Setup edge, access edge, then the commit edge; returns 1ns after the commit edge.
    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Data is sampled during the access phase, just after the second edge of the task.
    task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        d = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        presetn = 1'b0;
        #12;
        checks++;
        if (tmr_ovf !== 1'b0 || tmr_udf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got ovf=%b udf=%b want 0 0", tmr_ovf, tmr_udf);
        end
        @(negedge pclk);
        presetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apb_read(8'(i), rd);
            checks++;
            if (rd !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg%0d got %02h want 00", i, rd);
            end
        end
    endtask

    task automatic test_tdr_rw();
        logic [7:0] rd;
        logic [7:0] vals [2];
        vals[0] = 8'hA5;
        vals[1] = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            apb_write(8'h00, vals[i]);
            apb_read(8'h00, rd);
            checks++;
            if (rd !== vals[i]) begin
                errors++;
                $display("FAIL tdr_rw got %02h want %02h", rd, vals[i]);
            end
        end
        // TCR is 0 here so TCNT is idle at 0.
        apb_write(8'h03, 8'h77);
        apb_read(8'h03, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL tcnt_readonly got %02h want 00", rd);
        end
    endtask

    task automatic test_tcr_mask();
        logic [7:0] rd;
        logic [7:0] w;
        logic [7:0] exp;
        apb_write(8'h01, 8'hFF);
        apb_read(8'h01, rd);
        checks++;
        if (rd !== 8'hB3) begin
            errors++;
            $display("FAIL tcr_ff got %02h want b3", rd);
        end
        apb_write(8'h01, 8'h4C);
        apb_read(8'h01, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL tcr_4c got %02h want 00", rd);
        end
        for (int i = 0; i < 10; i++) begin
            w = 8'($urandom);
            exp = {w[7], 1'b0, w[5:4], 2'b00, w[1:0]};
            apb_write(8'h01, w);
            apb_read(8'h01, rd);
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL tcr_rand w=%02h got %02h want %02h", w, rd, exp);
            end
        end
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h00);
    endtask

    task automatic test_count_up_ovf();
        logic [7:0] rd;
        apb_write(8'h00, 8'hFD);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        // Ticks at edges 2, 4, 6 after the commit: FD -> FE -> FF -> 00.
        repeat (4) @(posedge pclk);
        apb_read(8'h03, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL up_tcnt got %02h want 00", rd);
        end
        apb_read(8'h02, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++;
            $display("FAIL up_tsr got %02h want 01", rd);
        end
        checks++;
        if (tmr_ovf !== 1'b1 || tmr_udf !== 1'b0) begin
            errors++;
            $display("FAIL up_pins got ovf=%b udf=%b want 1 0", tmr_ovf, tmr_udf);
        end
        apb_write(8'h02, 8'h00);
        apb_read(8'h02, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL up_clear got %02h want 00", rd);
        end
    endtask

    task automatic test_div4();
        logic [7:0] rd;
        apb_write(8'h00, 8'h10);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h11);
        // First /4 tick lands on the 4th edge after the commit.
        repeat (2) @(posedge pclk);
        apb_read(8'h03, rd);
        checks++;
        if (rd !== 8'h11) begin
            errors++;
            $display("FAIL div4_tcnt got %02h want 11", rd);
        end
    endtask

    task automatic test_count_down_udf();
        logic [7:0] rd;
        apb_write(8'h00, 8'h02);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h33);
        // Ticks at edges 16, 32, 48: 02 -> 01 -> 00 -> FF.
        repeat (46) @(posedge pclk);
        apb_read(8'h03, rd);
        checks++;
        if (rd !== 8'hFF) begin
            errors++;
            $display("FAIL down_tcnt got %02h want ff", rd);
        end
        apb_read(8'h02, rd);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL down_tsr got %02h want 02", rd);
        end
        checks++;
        if (tmr_udf !== 1'b1 || tmr_ovf !== 1'b0) begin
            errors++;
            $display("FAIL down_pins got ovf=%b udf=%b want 0 1", tmr_ovf, tmr_udf);
        end
        apb_write(8'h02, 8'h03);
        apb_read(8'h02, rd);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL down_write1 got %02h want 02", rd);
        end
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h00);
        apb_read(8'h02, rd);
        checks++;
        if (rd !== 8'h00 || tmr_udf !== 1'b0) begin
            errors++;
            $display("FAIL down_clear got %02h udf=%b want 00 0", rd, tmr_udf);
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] rd;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h12;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_wr_resp got pready=%b pslverr=%b want 1 0", pready, pslverr);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0) begin
            errors++;
            $display("FAIL idle_pready got %b want 0", pready);
        end
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_rd got %02h want 00", rd);
        end
        // Earlier TDR write of 0x02 must be untouched by the unmapped write.
        apb_read(8'h00, rd);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL unmapped_tdr got %02h want 02", rd);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        presetn = 1'b1;
        test_reset();
        test_tdr_rw();
        test_tcr_mask();
        test_count_up_ovf();
        test_div4();
        test_count_down_udf();
        test_unmapped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_bench.md
Name: test_bench

Overview:
- 8-bit programmable timer with an APB slave register interface.
- Holds a data register (TDR), a control register (TCR), a status register (TSR) and a read-only counter (TCNT).
- TCNT counts up or down on a prescaled pclk tick and flags overflow and underflow.
- Sits on the peripheral APB bus and is driven by the CPU bus-functional model.

Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data and register width

Ports:
- pclk  input  1  system clock. Single clock domain.
- presetn  input  1  reset, asynchronous and active-low.
- psel  input  1  APB select.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  register address.
- pwdata  input  8  write data.
- prdata  output  8  read data.
- pready  output  1  transfer complete.
- pslverr  output  1  error response; tied to 0.
- tmr_ovf  output  1  mirror of TSR[0].
- tmr_udf  output  1  mirror of TSR[1].

Behaviour:
- Reset: presetn low asynchronously clears TDR, TCR, TSR, TCNT, the prescaler, prdata, tmr_ovf and tmr_udf to 0x00/0.
- APB protocol:
  - pready = psel & penable; zero wait states.
  - Write commits on the pclk edge where psel & penable & pwrite.
  - Read: prdata is valid while psel & penable & !pwrite. prdata = 0x00 otherwise.
- Register map:
  - 0x00 TDR: R/W, all 8 bits.
  - 0x01 TCR: R/W. Writable bits are 7, 5, 4, 1, 0. Bits 6, 3, 2 are reserved: writes are ignored and they read 0. Readback = {w[7], 0, w[5:4], 00, w[1:0]}.
  - 0x02 TSR: bit0 = OVF, bit1 = UDF, bits 7:2 read 0.
    - Writing 0 to a set flag clears it; writing 1 has no effect.
  - 0x03 TCNT: read-only; writes are ignored.
  - Other addresses: reads return 0x00, writes are ignored, pslverr stays 0.
- TCR fields:
  - [7] LOAD: while 1, TCNT <= TDR every pclk and counting is suspended.
  - [5] DIR: 0 = count up, 1 = count down.
  - [4] EN: enables counting.
  - [1:0] CKS: tick period = pclk/2, /4, /8, /16 for 00, 01, 10, 11.
- Prescaler:
  - 4-bit free-running counter, active only while EN = 1.
  - Held at 0 while EN = 0.
  - A tick fires when prescaler bits [CKS:0] are all 1.
  - A CKS change mid-count takes effect on the next matching value; the prescaler is not reset.
- Counting, on a tick with EN = 1 and LOAD = 0:
  - TCNT +1 if DIR = 0, -1 if DIR = 1, modulo 256.
  - Wrap 0xFF -> 0x00 while counting up sets OVF.
  - Wrap 0x00 -> 0xFF while counting down sets UDF.
  - Flags are sticky until cleared by software.
- Priority:
  - LOAD overrides counting.
  - A hardware set of a flag wins over a software clear in the same cycle.
  - An APB write to TCR takes effect from the following cycle.
- Reset mid-operation: all state returns to reset values immediately; no APB response is required for an interrupted transfer.

Test Plan:
- Reset check: assert presetn low, release, read 0x00–0x03 -> all 0x00; tmr_ovf = tmr_udf = 0.
- TCR masking: write 0xFF to 0x01 -> read 0xB3. Write 0x4C -> read 0x00. Ten random writes -> each read equals {w[7], 0, w[5:4], 00, w[1:0]}.
- TDR R/W: write 0xA5, then 0x5A, to 0x00 -> each read back unchanged. Write 0x77 to 0x03 -> TCNT is unchanged.
- Count-up overflow:
  - TDR = 0xFD; TCR = 0x80 (load), then TCR = 0x10 (up, /2).
  - After 3 ticks (6 pclk) TCNT = 0x00, TSR = 0x01, tmr_ovf = 1.
  - Write 0x00 to TSR -> TSR = 0x00.
- Count-down underflow:
  - TDR = 0x02; load; then TCR = 0x33 (down, en, /16).
  - After 48 pclk TCNT = 0xFF, TSR = 0x02, tmr_udf = 1.
  - Write 0x03 to TSR -> flag stays set.
- Unmapped address: write 0x12 to 0x10, read 0x10 -> 0x00. pready = 1 in the access phase; pslverr = 0.
